counter_checker: RTL
====================

Name: counter_checker

Overview:
- Receive-side companion to the signed skip-value up/down counter.
- Samples the counter's output stream and infers the counting direction (mode) applied on each step.
- Flags any sample that breaks the counter's rules: wrong init, out-of-range value, forbidden value, or illegal step.
- Sits on the consumer side of the counter bus as a decoder and runtime monitor.

Parameters:
- W, 10, sample width (two's complement)
- INIT, -50, value required as first sample after reset
- MIN, -230, lowest legal value
- MAX, 235, highest legal value
- INV, -11, forbidden value
- INC, 5, up step
- DEC, 9, down step (magnitude)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- cnt_valid  in  1  cnt_in carries a sample this cycle
- cnt_in  in  W  signed counter sample
- mode_out  out  1  inferred direction of last checked step (1 = up, 0 = down)
- mode_valid  out  1  1-cycle pulse: mode_out updated
- err  out  1  sticky error flag
- err_code  out  3  0 none, 1 init mismatch, 2 out of range, 3 INV value, 4 bad step
- step_count  out  16  accepted steps, saturates at 0xFFFF
- fault_count  out  8  faults detected, saturates at 0xFF

Behaviour:
Reset (synchronous, clk edge with rst=1):
- All outputs 0.
- prev register = INIT.
- State = S_WAIT.
- rst has priority over every other event, including a valid sample in the same cycle.

States:
- S_WAIT: next valid sample is checked against range and INV, then must equal INIT.
  - Pass: prev <= sample, go to S_TRACK. No mode_valid pulse.
  - Fail: go to S_FAULT.
- S_TRACK: each valid sample s is checked against prev p.
- S_FAULT: absorbing until rst (see Optional Feature). Samples are ignored; outputs hold.

Expected values, computed in W+2-bit signed arithmetic (no wrap):
- up(p): p+2*INC if p == INV-INC; p if p+INC > MAX; otherwise p+INC.
- dn(p): p-2*DEC if p == INV+DEC; p if p-DEC < MIN; otherwise p-DEC.
- With default parameters up(p) != dn(p) for every legal p, so the classification is unambiguous.

Check order in S_TRACK (first failing rule wins):
1. s < MIN or s > MAX: code 2.
2. s == INV: code 3.
3. s == up(p): pass, mode_out=1.
4. s == dn(p): pass, mode_out=0.
5. Otherwise: code 4.

On pass:
- prev <= s.
- mode_valid pulses for one cycle.
- step_count += 1 (saturating).

On fail:
- err <= 1, err_code <= code.
- fault_count += 1 (saturating).
- mode_valid stays 0, prev unchanged.
- Go to S_FAULT.

Timing and boundary rules:
- Latency: every result is registered and appears on the cycle after the sampled edge.
- cnt_valid = 0: no state change; mode_valid = 0. Comparison is always against the last accepted sample, regardless of gaps.
- Hold at the limits is legal only in the matching direction:
  - 235 -> 235 is up; 235 -> 226 is down.
  - -230 -> -230 is down; -230 -> -225 is up.
- Reset mid-stream: clears all state and counters; the next valid sample must again equal INIT.

Optional Feature:
- Macro: CNT_CHK_RECOVER_EN.
- Defined:
  - S_FAULT is not absorbing.
  - The next valid sample that passes the range and INV checks becomes the new prev (no INIT or step check) and the block returns to S_TRACK.
  - A sample failing range or INV while in S_FAULT increments fault_count and updates err_code.
  - err stays sticky until rst.
  - fault_count can exceed 1.
- Undefined: S_FAULT is held until rst; fault_count is at most 1.
- Port list is identical in both builds.

Test Plan:
- Init and up: rst, then valid -50, -45, -40 -> no mode_valid on -50; mode_out=1 pulses for -45 and -40; step_count=2; err=0.
- Skip over INV: -16 -> -6 is accepted up; -2 -> -20 is accepted down; -16 -> -11 gives err=1, err_code=3.
- Limits: 235 -> 235 gives mode_out=1; -230 -> -230 gives mode_out=0; 232 -> 237 gives err_code=2.
- Bad init and bad step: first sample -45 gives err_code=1, fault_count=1. After reset: -50, -44 gives err_code=4, and later samples leave the outputs unchanged.
- Gaps and reset priority: -50, idle 3 cycles, -59 -> accepted down. rst asserted together with a valid -68 -> all outputs 0, state S_WAIT.
- With CNT_CHK_RECOVER_EN: -50, -40 (err_code 4), 100, 105 -> back in S_TRACK, mode_out=1 pulse for 105, err=1, fault_count=1.

Source files
------------

// File: rtl/counter_checker.sv
// Receive-side monitor for the signed skip-value up/down counter: infers step direction
// and flags rule violations. Define CNT_CHK_RECOVER_EN to let S_FAULT resynchronise on a legal sample.
module counter_checker #(
    parameter int W    = 10,
    parameter int INIT = -50,
    parameter int MIN  = -230,
    parameter int MAX  = 235,
    parameter int INV  = -11,
    parameter int INC  = 5,
    parameter int DEC  = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cnt_valid,
    input  logic [W-1:0] cnt_in,
    output logic         mode_out,
    output logic         mode_valid,
    output logic         err,
    output logic [2:0]   err_code,
    output logic [15:0]  step_count,
    output logic [7:0]   fault_count
);

    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] INIT_X = XW'(INIT);
    localparam logic signed [XW-1:0] MIN_X  = XW'(MIN);
    localparam logic signed [XW-1:0] MAX_X  = XW'(MAX);
    localparam logic signed [XW-1:0] INV_X  = XW'(INV);
    localparam logic signed [XW-1:0] INC_X  = XW'(INC);
    localparam logic signed [XW-1:0] DEC_X  = XW'(DEC);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic signed [XW-1:0] prev_r;
    logic signed [XW-1:0] sample_s;
    logic signed [XW-1:0] up_s;
    logic signed [XW-1:0] dn_s;
    logic [2:0]           code_s;
    logic                 hit_up_s;
    logic                 step_evt_s;
    logic                 fault_evt_s;
    logic                 load_prev_s;

    function automatic logic signed [XW-1:0] up_val(input logic signed [XW-1:0] p);
        logic signed [XW-1:0] r;
        if (p == INV_X - INC_X) begin
            r = p + INC_X + INC_X;
        end else if (p + INC_X > MAX_X) begin
            r = p;
        end else begin
            r = p + INC_X;
        end
        return r;
    endfunction

    function automatic logic signed [XW-1:0] dn_val(input logic signed [XW-1:0] p);
        logic signed [XW-1:0] r;
        if (p == INV_X + DEC_X) begin
            r = p - DEC_X - DEC_X;
        end else if (p - DEC_X < MIN_X) begin
            r = p;
        end else begin
            r = p - DEC_X;
        end
        return r;
    endfunction

    // Widening keeps the step arithmetic free of wrap near the limits.
    assign sample_s = {{(XW-W){cnt_in[W-1]}}, cnt_in};
    assign up_s     = up_val(prev_r);
    assign dn_s     = dn_val(prev_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample classification: first failing rule sets the code.
    always_comb begin
        code_s   = 3'd0;
        hit_up_s = 1'b0;
        if ((sample_s < MIN_X) || (sample_s > MAX_X)) begin
            code_s = 3'd2;
        end else if (sample_s == INV_X) begin
            code_s = 3'd3;
        end else begin
            case (state_r)
                S_WAIT: begin
                    if (sample_s != INIT_X) begin
                        code_s = 3'd1;
                    end else begin
                        code_s = 3'd0;
                    end
                end
                S_TRACK: begin
                    if (sample_s == up_s) begin
                        hit_up_s = 1'b1;
                    end else if (sample_s == dn_s) begin
                        hit_up_s = 1'b0;
                    end else begin
                        code_s = 3'd4;
                    end
                end
                S_FAULT: code_s = 3'd0;
                default: code_s = 3'd0;
            endcase
        end
    end

    // Per-state event decode for the datapath.
    always_comb begin
        step_evt_s  = 1'b0;
        fault_evt_s = 1'b0;
        load_prev_s = 1'b0;
        if (cnt_valid) begin
            case (state_r)
                S_WAIT, S_TRACK: begin
                    load_prev_s = (code_s == 3'd0);
                    fault_evt_s = (code_s != 3'd0);
                    step_evt_s  = (state_r == S_TRACK) && (code_s == 3'd0);
                end
                S_FAULT: begin
`ifdef CNT_CHK_RECOVER_EN
                    load_prev_s = (code_s == 3'd0);
                    fault_evt_s = (code_s != 3'd0);
`else
                    load_prev_s = 1'b0;
                    fault_evt_s = 1'b0;
`endif
                end
                default: begin
                    load_prev_s = 1'b0;
                    fault_evt_s = 1'b0;
                end
            endcase
        end else begin
            load_prev_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_WAIT: begin
                if (fault_evt_s) begin
                    state_nxt_s = S_FAULT;
                end else if (load_prev_s) begin
                    state_nxt_s = S_TRACK;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_TRACK: begin
                if (fault_evt_s) begin
                    state_nxt_s = S_FAULT;
                end else begin
                    state_nxt_s = S_TRACK;
                end
            end
            S_FAULT: begin
                if (load_prev_s) begin
                    state_nxt_s = S_TRACK;
                end else begin
                    state_nxt_s = S_FAULT;
                end
            end
            default: state_nxt_s = S_WAIT;
        endcase
    end

    // Registered outputs, reference sample and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r      <= INIT_X;
            mode_out    <= 1'b0;
            mode_valid  <= 1'b0;
            err         <= 1'b0;
            err_code    <= 3'd0;
            step_count  <= 16'd0;
            fault_count <= 8'd0;
        end else begin
            mode_valid <= step_evt_s;
            if (load_prev_s) begin
                prev_r <= sample_s;
            end
            if (step_evt_s) begin
                mode_out <= hit_up_s;
                if (step_count != 16'hFFFF) begin
                    step_count <= step_count + 16'd1;
                end
            end
            if (fault_evt_s) begin
                err      <= 1'b1;
                err_code <= code_s;
                if (fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'd1;
                end
            end
        end
    end

endmodule
